// File: rtl/bit_stream_serializer_pkg.sv
// bit_stream_serializer_pkg: shifter state encoding and holding FIFO depth shared by the serial path.
package bit_stream_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int unsigned HOLD_DEPTH = 2;

endpackage

// File: rtl/ser_hold_fifo.sv
// ser_hold_fifo: small circular holding FIFO with push/pop strobes and an occupancy count.
module ser_hold_fifo #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 2,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [CNT_W-1:0]  cnt_q;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= nxt(wr_q);
            if (pop_i) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: parallel words through a 2-deep holding FIFO, shifted out one bit per cycle
// with registered x / x_valid / frame_start.
module bit_stream_serializer
    import bit_stream_serializer_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              x,
    output logic              x_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam int unsigned CNT_W = $clog2(HOLD_DEPTH + 1);

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d, head, src, src_nxt;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              x_q, x_d, fs_q, fs_d;
    logic              push, pop, avail, last, shift_en, src_bit;
    logic [CNT_W-1:0]  count;

    ser_hold_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (HOLD_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .data_i (in_data),
        .pop_i  (pop),
        .data_o (head),
        .count_o(count)
    );

    assign in_ready = count != CNT_W'(HOLD_DEPTH);
    assign push     = in_valid && in_ready;
    assign avail    = count != '0;
    assign last     = bit_q == BIT_W'(DATA_W - 1);
    // A new word loads either from idle or on the edge that ends the last bit, so words run gap-free.
    assign pop      = avail && (state_q == IDLE || last);
    assign shift_en = pop || (state_q == SHIFT && !last);
    assign src      = pop ? head : sh_q;
    assign src_bit  = MSB_FIRST ? src[DATA_W-1] : src[0];
    assign src_nxt  = MSB_FIRST ? src << 1 : src >> 1;

    always_comb begin
        state_d = pop ? SHIFT : (state_q == SHIFT && last) ? IDLE : state_q;
        sh_d    = shift_en ? src_nxt : sh_q;
        bit_d   = (shift_en && !pop) ? bit_q + BIT_W'(1) : '0;
        x_d     = shift_en ? src_bit : IDLE_BIT;
        fs_d    = pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bit_q   <= '0;
            x_q     <= IDLE_BIT;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            x_q     <= x_d;
            fs_q    <= fs_d;
        end
    end

    assign x           = x_q;
    assign x_valid     = state_q == SHIFT;
    assign frame_start = fs_q;
    assign busy        = (state_q == SHIFT) || avail;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb_bit_stream_serializer: directed checks of MSB-first and LSB-first serializers plus a 1001 detector downstream.
module tb_bit_stream_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] m_data, l_data;
    logic       m_valid, m_ready, m_x, m_xv, m_fs, m_busy;
    logic       l_valid, l_ready, l_x, l_xv, l_fs, l_busy;
    logic [2:0] det_q;
    logic       z;
    int         n_chk = 0;
    int         n_fail = 0;
    int         idx, nb;
    logic       acc;
    logic [7:0]  w;
    logic [15:0] w2;
    logic [31:0] words, got;

    always #5 clk = ~clk;

    bit_stream_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .rst(rst), .in_data(m_data), .in_valid(m_valid), .in_ready(m_ready),
        .x(m_x), .x_valid(m_xv), .frame_start(m_fs), .busy(m_busy)
    );

    bit_stream_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
        .x(l_x), .x_valid(l_xv), .frame_start(l_fs), .busy(l_busy)
    );

    // Overlapping Moore 1001 detector fed by the MSB-first stream.
    function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
        case (s)
            3'd0:    return b ? 3'd1 : 3'd0;
            3'd1:    return b ? 3'd1 : 3'd2;
            3'd2:    return b ? 3'd1 : 3'd3;
            3'd3:    return b ? 3'd4 : 3'd0;
            default: return b ? 3'd1 : 3'd2;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) det_q <= 3'd0;
        else if (m_xv) det_q <= det_next(det_q, m_x);
    end

    assign z = det_q == 3'd4;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        m_data = 8'h00; m_valid = 1'b0; l_data = 8'h00; l_valid = 1'b0;
        #2;
        chk("rst in_ready", m_ready, 1);
        chk("rst busy", m_busy, 0);
        chk("rst x_valid", m_xv, 0);
        chk("rst x", m_x, 0);
        chk("rst frame_start", m_fs, 0);
        chk("rst lsb in_ready", l_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step;
        chk("idle x_valid", m_xv, 0);

        // 8'h90 into an idle block
        w = 8'h90;
        m_data = w; m_valid = 1'b1;
        step;
        m_valid = 1'b0;
        chk("t1 latency x_valid", m_xv, 0);
        chk("t1 busy queued", m_busy, 1);
        for (int i = 0; i < 8; i++) begin
            step;
            chk("t1 x", m_x, w[7-i]);
            chk("t1 x_valid", m_xv, 1);
            chk("t1 frame_start", m_fs, i == 0);
        end
        step;
        chk("t1 end x", m_x, 0);
        chk("t1 end x_valid", m_xv, 0);
        chk("t1 end busy", m_busy, 0);

        // back-to-back A5, 3C
        w2 = 16'hA53C;
        m_data = 8'hA5; m_valid = 1'b1;
        step;
        m_data = 8'h3C;
        step;
        m_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("t2 x", m_x, w2[15-i]);
            chk("t2 x_valid", m_xv, 1);
            chk("t2 frame_start", m_fs, (i == 0) || (i == 8));
            step;
        end
        chk("t2 end x_valid", m_xv, 0);
        chk("t2 end busy", m_busy, 0);

        // four words with in_valid held, throttled by the shift rate
        words = 32'hC35AF00F; idx = 0; nb = 0; got = 32'h0;
        for (int c = 0; c < 40; c++) begin
            m_valid = idx < 4;
            m_data = words[31-8*(idx%4) -: 8];
            if (m_xv) begin
                got = {got[30:0], m_x};
                nb++;
            end
            if (c == 2) chk("t3 ready before full", m_ready, 1);
            if (c == 3) begin
                chk("t3 ready full", m_ready, 0);
                chk("t3 accepted", idx, 3);
                chk("t3 busy", m_busy, 1);
            end
            acc = m_valid && m_ready;
            step;
            if (acc) idx++;
        end
        m_valid = 1'b0;
        chk("t3 all accepted", idx, 4);
        chk("t3 bit count", nb, 32);
        chk("t3 stream", got, words);
        chk("t3 end busy", m_busy, 0);

        // LSB-first 8'h01
        w = 8'h01;
        l_data = w; l_valid = 1'b1;
        step;
        l_valid = 1'b0;
        chk("t4 latency x_valid", l_xv, 0);
        for (int i = 0; i < 8; i++) begin
            step;
            chk("t4 x", l_x, w[i]);
            chk("t4 x_valid", l_xv, 1);
            chk("t4 frame_start", l_fs, i == 0);
        end
        step;
        chk("t4 end x_valid", l_xv, 0);
        chk("t4 end x", l_x, 0);

        // reset during bit 4 with one word queued
        m_data = 8'hFF; m_valid = 1'b1;
        step;
        m_data = 8'h81;
        step;
        m_valid = 1'b0;
        chk("t5 first bit", m_fs, 1);
        repeat (4) step;
        chk("t5 bit4 x_valid", m_xv, 1);
        chk("t5 bit4 busy", m_busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5 async x", m_x, 0);
        chk("t5 async x_valid", m_xv, 0);
        chk("t5 async frame_start", m_fs, 0);
        chk("t5 async in_ready", m_ready, 1);
        chk("t5 async busy", m_busy, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step;
            chk("t5 queued word dropped", m_xv, 0);
        end
        chk("t5 busy after release", m_busy, 0);

        // 1001_0010 into the detector, first word after reset
        w = 8'h92;
        m_data = w; m_valid = 1'b1;
        step;
        m_valid = 1'b0;
        chk("t6 latency x_valid", m_xv, 0);
        for (int k = 0; k < 9; k++) begin
            step;
            if (k < 8) chk("t6 x", m_x, w[7-k]);
            chk("t6 z", z, (k == 4) || (k == 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_stream_serializer.md
BIT_STREAM_SERIALIZER -- requirements
Module: bit_stream_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: width of each parallel word (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = bit DATA_W-1 shifted out first, 0 = bit 0 first.
REQ-003 The block SHALL have parameter IDLE_BIT, default 0: value driven on x when no word is being shifted.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_data, input, DATA_W bits: parallel word to serialize.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block can accept a word this cycle.
REQ-009 The block SHALL have port x, output, 1 bit: serial bit stream feeding the downstream sequence detector.
REQ-010 The block SHALL have port x_valid, output, 1 bit: x carries a data bit this cycle.
REQ-011 The block SHALL have port frame_start, output, 1 bit: high on the first bit of each word.
REQ-012 The block SHALL have port busy, output, 1 bit: shifter or holding FIFO non-empty.

Function
REQ-013 A word SHALL be accepted on a rising edge where in_valid && in_ready; no other condition consumes in_data.
REQ-014 Accepted words SHALL enter a 2-entry holding FIFO; in_ready SHALL equal (fifo_count != 2), derived from registered state only.
REQ-015 The shifter SHALL have exactly two states: IDLE (x = IDLE_BIT, x_valid = 0) and SHIFT (x = current bit, x_valid = 1).
REQ-016 IDLE -> SHIFT SHALL occur on the edge after the FIFO becomes non-empty; the head word is popped and loaded on that same edge.
REQ-017 Latency: a word accepted at edge N into an empty idle block SHALL present its first bit on x during the cycle following edge N+1.
REQ-018 In SHIFT, one bit SHALL be output per cycle for exactly DATA_W cycles, tracked by a bit counter of width clog2(DATA_W).
REQ-019 On the edge ending the last bit, if the FIFO is non-empty the next word SHALL load with zero idle cycles; otherwise the state SHALL return to IDLE.
REQ-020 Simultaneous push and pop in one cycle SHALL leave fifo_count unchanged and preserve word order.
REQ-021 Word order on x SHALL equal acceptance order; no word SHALL be dropped or duplicated.
REQ-022 frame_start SHALL be high only during the first bit cycle of each word, including back-to-back words.
REQ-023 busy SHALL be (state == SHIFT) || (fifo_count != 0).
REQ-024 x, x_valid and frame_start SHALL be registered outputs; in_ready and busy SHALL be decoded from registered state only.

Reset
REQ-025 While rst is low: state = IDLE, fifo_count = 0, bit counter = 0, x = IDLE_BIT, x_valid = 0, frame_start = 0, in_ready = 1, busy = 0.
REQ-026 Reset asserted mid-word SHALL take effect immediately (asynchronously) and discard the partial word and all FIFO contents.
REQ-027 The first word accepted after reset release SHALL follow REQ-017 timing exactly.

Structure
REQ-028 State encodings (IDLE, SHIFT) and the FIFO depth constant (2) SHALL live in a shared package/include used by the serial-path blocks.
REQ-029 The holding FIFO SHALL be a sub-module named ser_hold_fifo (parameters DATA_W and depth, push/pop/count interface); the shifter FSM SHALL be in the top.

Verification
REQ-030 The bench SHALL cover: DATA_W=8, MSB_FIRST=1, send 8'h90 into an idle block -> x = 1,0,0,1,0,0,0,0 on 8 consecutive cycles starting at edge N+1, with frame_start only on the first bit, then x = 0 and x_valid = 0.
REQ-031 The bench SHALL cover: back-to-back 8'hA5, 8'h3C with in_valid held high -> 16 contiguous x_valid cycles, bit sequence 10100101 00111100, and frame_start high at bits 0 and 8.
REQ-032 The bench SHALL cover: in_valid held high with 4 words while the output is stalled by the shift rate -> in_ready falls after shifter plus 2 FIFO entries are occupied, and all 4 words emerge in order.
REQ-033 The bench SHALL cover: MSB_FIRST=0, send 8'h01 -> x = 1 then seven 0s.
REQ-034 The bench SHALL cover: rst pulled low during bit 4 of a word with one word queued -> outputs reach their reset values immediately, and after release the queued word never appears on x.
REQ-035 The bench SHALL cover: connect x to the downstream 1001 overlapping Moore detector and send 8'b1001_0010 MSB-first -> the detector output z pulses twice, one cycle after bit 3 and one cycle after bit 6.
